// File: rtl/setup_pkg.sv
// Shared types, key codes and helpers for the lock setup-mode editor.
package setup_pkg;

  localparam logic [3:0]  BCD_BLANK     = 4'hF;
  localparam logic [3:0]  KEY_CONFIRM   = 4'hF;
  localparam logic [3:0]  KEY_CANCEL    = 4'hE;
  localparam int          PIN_W         = 17;
  localparam int          STEP_W        = 5;
  localparam logic [23:0] BCD_ALL_BLANK = {6{BCD_BLANK}};

  typedef struct packed {
    logic [3:0] bcd0;
    logic [3:0] bcd1;
    logic [3:0] bcd2;
    logic [3:0] bcd3;
    logic [3:0] bcd4;
    logic [3:0] bcd5;
  } bcdPac_t;

  typedef enum logic [1:0] {FLD_STATUS, FLD_TIME, FLD_PIN} fld_t;

  function automatic int cfg_w(input int num_pins);
    return 15 + PIN_W * (num_pins + 1);
  endfunction

  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    int t;
    int u;
    t = int'(v) / 10;
    u = int'(v) % 10;
    return {4'(t), 4'(u)};
  endfunction

  // Step 1 is bip status, 2/3 are timings, then pin digits on even steps and pin status on odd ones.
  function automatic fld_t step_fld(input logic [STEP_W-1:0] st);
    if (st == STEP_W'(2) || st == STEP_W'(3)) return FLD_TIME;
    if (st >= STEP_W'(4) && !st[0]) return FLD_PIN;
    return FLD_STATUS;
  endfunction

endpackage

// File: rtl/setup_step_fmt.sv
// Combinational display formatter: step number plus field type/value to six BCD digits.
module setup_step_fmt
  import setup_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        fld,
  input  logic [15:0]       val,
  output logic [23:0]       bcd
);

  bcdPac_t    b;
  logic [7:0] st2;

  always_comb begin
    st2    = to_bcd2(7'(step));
    b.bcd0 = st2[7:4];
    b.bcd1 = st2[3:0];
    case (fld)
      FLD_STATUS: {b.bcd2, b.bcd3, b.bcd4, b.bcd5} = {BCD_BLANK, BCD_BLANK, BCD_BLANK, 3'b000, val[0]};
      FLD_TIME:   {b.bcd2, b.bcd3, b.bcd4, b.bcd5} = {BCD_BLANK, BCD_BLANK, val[7:0]};
      default:    {b.bcd2, b.bcd3, b.bcd4, b.bcd5} = val;
    endcase
  end

  assign bcd = b;

endmodule

// File: rtl/setup_menu.sv
// Keypad-driven setup editor; result returned two cycles after the final key via setup_end low.
// Optional idle auto-cancel is built when SETUP_TIMEOUT_EN is defined.
module setup_menu
  import setup_pkg::*;
#(
  parameter  int NUM_PINS       = 4,
  parameter  int TIME_MIN       = 5,
  parameter  int TIME_MAX       = 60,
  parameter  int TIMEOUT_CYCLES = 30000000,
  localparam int CFG_W          = cfg_w(NUM_PINS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             setup_on,
  input  logic [CFG_W-1:0] cfg_old,
  output logic [CFG_W-1:0] cfg_new,
  output logic             setup_end,
  output logic             setup_abort,
  output logic [23:0]      bcd_out,
  output logic             bcd_enable
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(2 * NUM_PINS + 2);
  localparam int                MST_LO = PIN_W * NUM_PINS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EDIT, S_DONE, S_WAIT_OFF} state_t;

  state_t             state_q, state_d;
  logic [CFG_W-1:0]   work_q, work_d, cfg_new_q, cfg_new_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [15:0]        buf_q, buf_d;
  logic               abort_q, abort_d, setup_end_q, setup_end_d;
  logic               setup_abort_q, setup_abort_d, bcd_en_q, bcd_en_d;
  logic               key_valid_q;
  logic [23:0]        bcd_q, bcd_d, fmt_bcd;
  logic               press, is_digit, tmo_hit;
  fld_t               fld, fld_nxt;
  int                 lo, tval;

  function automatic int pin_lo(input logic [STEP_W-1:0] st);
    return PIN_W * (NUM_PINS - (int'(st) - 1) / 2);
  endfunction

  // Entry buffer holds the field being edited, in display digit order.
  function automatic logic [15:0] load_buf(input logic [CFG_W-1:0] w, input logic [STEP_W-1:0] st);
    int          l;
    logic [15:0] r;
    l = pin_lo(st);
    r = '0;
    case (step_fld(st))
      FLD_STATUS: r[0]   = (st == STEP_W'(1)) ? w[CFG_W-1] : w[l+16];
      FLD_TIME:   r[7:0] = to_bcd2((st == STEP_W'(2)) ? w[CFG_W-2 -: 7] : w[CFG_W-9 -: 7]);
      default:    r      = w[l +: 16];
    endcase
    return r;
  endfunction

  assign press    = key_valid & ~key_valid_q;
  assign is_digit = (key_code <= 4'd9);
  assign fld_nxt  = step_fld(step_d);

  setup_step_fmt u_fmt (
    .step (step_d),
    .fld  (fld_nxt),
    .val  (buf_d),
    .bcd  (fmt_bcd)
  );

`ifdef SETUP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (state_q != S_EDIT || press) tmo_d = '0;
  end

  assign tmo_hit = (state_q == S_EDIT) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    step_d        = step_q;
    buf_d         = buf_q;
    abort_d       = abort_q;
    cfg_new_d     = cfg_new_q;
    setup_end_d   = setup_end_q;
    setup_abort_d = setup_abort_q;
    bcd_en_d      = bcd_en_q;
    fld           = step_fld(step_q);
    lo            = pin_lo(step_q);
    tval          = 0;
    case (state_q)
      S_IDLE: begin
        bcd_en_d = 1'b0;
        if (setup_on) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!setup_on) begin
          state_d = S_IDLE;
        end else begin
          work_d   = cfg_old;
          step_d   = STEP_W'(1);
          buf_d    = load_buf(cfg_old, STEP_W'(1));
          abort_d  = 1'b0;
          bcd_en_d = 1'b1;
          state_d  = S_EDIT;
        end
      end
      S_EDIT: begin
        // Losing setup_on outranks any key arriving in the same cycle.
        if (!setup_on) begin
          state_d  = S_IDLE;
          bcd_en_d = 1'b0;
        end else if (tmo_hit || (press && key_code == KEY_CANCEL)) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (press && key_code == KEY_CONFIRM) begin
          if (fld == FLD_TIME) begin
            tval = int'(buf_q[7:4]) * 10 + int'(buf_q[3:0]);
            if (tval < TIME_MIN)      tval = TIME_MIN;
            else if (tval > TIME_MAX) tval = TIME_MAX;
            if (step_q == STEP_W'(2)) work_d[CFG_W-2 -: 7] = 7'(tval);
            else                      work_d[CFG_W-9 -: 7] = 7'(tval);
          end
          if (step_q == LAST) begin
            state_d = S_DONE;
          end else begin
            step_d = step_q + 1'b1;
            buf_d  = load_buf(work_d, step_d);
          end
        end else if (press && is_digit) begin
          case (fld)
            FLD_STATUS: begin
              if (key_code <= 4'd1) begin
                buf_d = {15'd0, key_code[0]};
                if (step_q == STEP_W'(1)) work_d[CFG_W-1] = key_code[0];
                else                      work_d[lo+16]   = key_code[0];
              end
            end
            FLD_TIME: buf_d = {8'h00, buf_q[3:0], key_code};
            default: begin
              buf_d            = {buf_q[11:0], key_code};
              work_d[lo +: 16] = buf_d;
            end
          endcase
        end
      end
      S_DONE: begin
        cfg_new_d                    = abort_q ? cfg_old : work_q;
        cfg_new_d[MST_LO +: PIN_W]   = cfg_old[MST_LO +: PIN_W];
        setup_abort_d                = abort_q;
        setup_end_d                  = 1'b0;
        bcd_en_d                     = 1'b0;
        state_d                      = S_WAIT_OFF;
      end
      S_WAIT_OFF: begin
        if (!setup_on) begin
          setup_end_d   = 1'b1;
          setup_abort_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display shows the state being entered, so it tracks edits with no extra cycle.
  always_comb begin
    bcd_d = BCD_ALL_BLANK;
    if (state_d == S_EDIT) bcd_d = fmt_bcd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      work_q        <= '0;
      step_q        <= '0;
      buf_q         <= '0;
      abort_q       <= 1'b0;
      cfg_new_q     <= '0;
      setup_end_q   <= 1'b1;
      setup_abort_q <= 1'b0;
      bcd_en_q      <= 1'b0;
      bcd_q         <= BCD_ALL_BLANK;
      key_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      step_q        <= step_d;
      buf_q         <= buf_d;
      abort_q       <= abort_d;
      cfg_new_q     <= cfg_new_d;
      setup_end_q   <= setup_end_d;
      setup_abort_q <= setup_abort_d;
      bcd_en_q      <= bcd_en_d;
      bcd_q         <= bcd_d;
      key_valid_q   <= key_valid;
    end
  end

  assign cfg_new     = cfg_new_q;
  assign setup_end   = setup_end_q;
  assign setup_abort = setup_abort_q;
  assign bcd_out     = bcd_q;
  assign bcd_enable  = bcd_en_q;

endmodule

// File: tb/tb_setup_menu.sv
// Directed key sequences; expected handshake results are queued at the final key and popped by a monitor.
`timescale 1ns/1ps
module tb_setup_menu;
  import setup_pkg::*;

  localparam int CW  = 15 + 17 * 5;
  localparam int CW2 = 15 + 17 * 3;

  logic           clk = 1'b0, rst = 1'b1, key_valid = 1'b0, setup_on = 1'b0, setup_on2 = 1'b0;
  logic [3:0]     key_code = 4'd0;
  logic [CW-1:0]  cfg_old, cfg_new;
  logic [CW2-1:0] cfg2, cfg_new2;
  logic           setup_end, setup_abort, bcd_enable;
  logic           setup_end2, setup_abort2, bcd_enable2;
  logic [23:0]    bcd_out, bcd_out2;
  int             cyc = 0, n_checks = 0, n_fail = 0;

  logic [CW-1:0]  sb_cfg[$];
  logic           sb_ab[$];
  int             sb_cyc[$];

  setup_menu u_dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .setup_on(setup_on),
    .cfg_old(cfg_old), .cfg_new(cfg_new), .setup_end(setup_end), .setup_abort(setup_abort),
    .bcd_out(bcd_out), .bcd_enable(bcd_enable)
  );

  setup_menu #(.NUM_PINS(2)) u_dut2 (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .setup_on(setup_on2),
    .cfg_old(cfg2), .cfg_new(cfg_new2), .setup_end(setup_end2), .setup_abort(setup_abort2),
    .bcd_out(bcd_out2), .bcd_enable(bcd_enable2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_last(input logic [3:0] k, input logic [CW-1:0] c, input logic ab);
    sb_cfg.push_back(c);
    sb_ab.push_back(ab);
    sb_cyc.push_back(cyc + 2);
    press(k);
  endtask

  function automatic logic [CW-1:0] mk4(input logic bs, input int bt, input int lt, input logic [16:0] m,
                                        input logic [16:0] p1, input logic [16:0] p2,
                                        input logic [16:0] p3, input logic [16:0] p4);
    return {bs, 7'(bt), 7'(lt), m, p1, p2, p3, p4};
  endfunction

  // Monitor: every falling setup_end must match the oldest queued result.
  initial begin
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && setup_end === 1'b0) begin
        chk("pending_result", 128'(sb_cfg.size() != 0), 128'(1));
        if (sb_cfg.size() != 0) begin
          chk("result_cfg", cfg_new, sb_cfg.pop_front());
          chk("result_abort", setup_abort, sb_ab.pop_front());
          chk("result_latency", cyc, sb_cyc.pop_front());
        end
      end
      prev = setup_end;
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_old = mk4(1'b1, 20, 30, {1'b1, 16'h9876}, {1'b1, 16'h1111}, {1'b0, 16'h2222},
                  {1'b1, 16'h3333}, {1'b0, 16'h4444});
    cfg2    = {1'b0, 7'd10, 7'd15, 17'h01234, 17'h15678, 17'h19999};
    cycles(2);
    chk("rst_setup_end", setup_end, 1);
    chk("rst_abort", setup_abort, 0);
    chk("rst_bcd_en", bcd_enable, 0);
    chk("rst_bcd", bcd_out, 24'hFFFFFF);
    chk("rst_cfg_new", cfg_new, 0);
    rst = 1'b0;
    cycles(1);

    // Walk straight through with F: result equals cfg_old.
    setup_on = 1'b1;
    cycles(2);
    chk("s1_display", bcd_out, 24'h01FFF1);
    chk("s1_enable", bcd_enable, 1);
    repeat (9) press(KEY_CONFIRM);
    chk("s10_display", bcd_out, 24'h104444);
    press_last(KEY_CONFIRM, cfg_old, 1'b0);
    chk("done_blank", bcd_out, 24'hFFFFFF);
    cycles(2);
    chk("wait_off_hold", setup_end, 0);
    setup_on = 1'b0;
    cycles(1);
    chk("release_end", setup_end, 1);
    chk("release_abort", setup_abort, 0);

    // Timing clamp and pin edits.
    setup_on = 1'b1;
    cycles(2);
    press(KEY_CONFIRM);
    chk("bip_time_display", bcd_out, 24'h02FF20);
    press(4'd7);
    press(4'd5);
    chk("time_entry_75", bcd_out, 24'h02FF75);
    press(KEY_CONFIRM);
    chk("lock_time_display", bcd_out, 24'h03FF30);
    press(4'd0);
    press(4'd3);
    press(KEY_CONFIRM);
    chk("pin1_display", bcd_out, 24'h041111);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd9);
    chk("pin1_shift", bcd_out, 24'h042349);
    press(KEY_CONFIRM);
    chk("pin2_status_show", bcd_out, 24'h05FFF0);
    press(4'd7);
    chk("status_ignores_7", bcd_out, 24'h05FFF0);
    press(4'd1);
    chk("status_set_1", bcd_out, 24'h05FFF1);
    press(KEY_CONFIRM);
    chk("pin2_digits", bcd_out, 24'h062222);
    repeat (4) press(KEY_CONFIRM);
    press_last(KEY_CONFIRM, mk4(1'b1, 60, 5, {1'b1, 16'h9876}, {1'b1, 16'h2349}, {1'b1, 16'h2222},
                                {1'b1, 16'h3333}, {1'b0, 16'h4444}), 1'b0);
    setup_on = 1'b0;
    cycles(2);

    // Edits then cancel at step 6.
    setup_on = 1'b1;
    cycles(2);
    press(4'd0); press(KEY_CONFIRM);
    press(4'd4); press(4'd4); press(KEY_CONFIRM);
    press(KEY_CONFIRM);
    press(4'd8); press(KEY_CONFIRM);
    press(4'd1); press(KEY_CONFIRM);
    press_last(KEY_CANCEL, cfg_old, 1'b1);
    cycles(3);
    chk("abort_hold_end", setup_end, 0);
    chk("abort_hold_flag", setup_abort, 1);
    setup_on = 1'b0;
    cycles(1);
    chk("abort_release_end", setup_end, 1);
    chk("abort_release_flag", setup_abort, 0);

    // setup_on falls at step 3 together with a cancel key: no handshake.
    setup_on = 1'b1;
    cycles(2);
    press(KEY_CONFIRM);
    press(KEY_CONFIRM);
    chk("drop_step3", bcd_out, 24'h03FF30);
    key_code  = KEY_CANCEL;
    key_valid = 1'b1;
    setup_on  = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    chk("drop_bcd", bcd_out, 24'hFFFFFF);
    chk("drop_enable", bcd_enable, 0);
    chk("drop_end", setup_end, 1);
    cycles(3);
    chk("drop_end_later", setup_end, 1);

    // Held key acts once.
    setup_on = 1'b1;
    cycles(2);
    chk("restart_s1", bcd_out, 24'h01FFF1);
    key_code  = KEY_CONFIRM;
    key_valid = 1'b1;
    cycles(50);
    key_valid = 1'b0;
    cycles(1);
    chk("held_key_once", bcd_out, 24'h02FF20);
    press(KEY_CONFIRM);
    chk("after_held_key", bcd_out, 24'h03FF30);

    // Reset mid-session clears cfg_new.
    rst = 1'b1;
    cycles(1);
    chk("midrst_cfg", cfg_new, 0);
    chk("midrst_end", setup_end, 1);
    chk("midrst_bcd", bcd_out, 24'hFFFFFF);
    setup_on = 1'b0;
    rst      = 1'b0;
    cycles(2);

    // Two-PIN build ends at step 6.
    setup_on2 = 1'b1;
    cycles(2);
    chk("np2_s1", bcd_out2, 24'h01FFF0);
    chk("np2_enable", bcd_enable2, 1);
    repeat (4) press(KEY_CONFIRM);
    chk("np2_s5", bcd_out2, 24'h05FFF1);
    press(KEY_CONFIRM);
    chk("np2_s6", bcd_out2, 24'h069999);
    chk("np2_not_done", setup_end2, 1);
    key_code  = KEY_CONFIRM;
    key_valid = 1'b1;
    @(negedge clk);
    chk("np2_edge1", setup_end2, 1);
    key_valid = 1'b0;
    @(negedge clk);
    chk("np2_edge2", setup_end2, 0);
    chk("np2_cfg", cfg_new2, cfg2);
    chk("np2_abort", setup_abort2, 0);
    setup_on2 = 1'b0;
    cycles(2);
    chk("np2_release", setup_end2, 1);

    chk("scoreboard_drained", sb_cfg.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
